// File: rtl/writeback_merge_stage.sv
// writeback_merge_stage: aligns/extends load data, merges split loads, queues register-file writes
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     memory-stage beat handshake
//   in_is_load            beat carries load data (else ALU result passthrough)
//   in_split              first beat of a word-crossing load
//   in_load_op            LB/LH/LW/LBU/LHU
//   in_rd                 destination register (0 discards the result)
//   in_alu_result         ALU result; [1:0] is the load byte offset
//   in_rdata              raw memory word for this beat
//   wb_valid/wb_ready     register-file write handshake
//   wb_rd, wb_data        queue head
//   err_split             sticky split-seen flag when merging is compiled out
//
// Build option: define KIANV_WB_MISALIGNED_EN to compile in the two-beat merge.

package writeback_merge_stage_pkg;
  typedef enum logic [2:0] {
    LOAD_OP_LB  = 3'd0,
    LOAD_OP_LH  = 3'd1,
    LOAD_OP_LW  = 3'd2,
    LOAD_OP_LBU = 3'd4,
    LOAD_OP_LHU = 3'd5
  } LoadOp_t;
endpackage

module writeback_merge_stage
  import writeback_merge_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_split,
  input  LoadOp_t     in_load_op,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_split
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    rd_q   [FIFO_DEPTH];
  logic [31:0]   data_q [FIFO_DEPTH];
  logic          accept, enq, push, pop;
  logic [31:0]   res;
  logic [4:0]    res_rd;

  function automatic logic [31:0] extend(input logic [31:0] w, input LoadOp_t op);
    return op == LOAD_OP_LB  ? {{24{w[7]}}, w[7:0]} :
           op == LOAD_OP_LBU ? {24'b0, w[7:0]} :
           op == LOAD_OP_LH  ? {{16{w[15]}}, w[15:0]} :
           op == LOAD_OP_LHU ? {16'b0, w[15:0]} : w;
  endfunction

  assign in_ready = !rst && (count < (AW+1)'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign wb_valid = count != '0;
  assign wb_rd    = rd_q[rd_ptr];
  assign wb_data  = data_q[rd_ptr];
  assign pop      = wb_ready && wb_valid;
  assign push     = enq && (res_rd != 5'd0);

`ifdef KIANV_WB_MISALIGNED_EN
  typedef enum logic {IDLE, WAIT_HI} state_t;
  state_t        state, state_n;
  logic [31:0]   lo_data;
  LoadOp_t       lo_op;
  logic [4:0]    lo_rd;
  logic [1:0]    lo_off;

  assign err_split = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lo_data <= '0;
      lo_op   <= LOAD_OP_LB;
      lo_rd   <= '0;
      lo_off  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && accept && in_is_load && in_split) begin
        lo_data <= in_rdata;
        lo_op   <= in_load_op;
        lo_rd   <= in_rd;
        lo_off  <= in_alu_result[1:0];
      end
    end
  end

  // The high beat's own sideband is ignored; the latched low-beat fields drive the merge.
  always_comb begin
    state_n = state;
    enq     = 1'b0;
    res     = in_alu_result;
    res_rd  = in_rd;
    if (state == WAIT_HI) begin
      res     = extend(32'({in_rdata, lo_data} >> {lo_off, 3'b000}), lo_op);
      res_rd  = lo_rd;
      enq     = accept;
      state_n = accept ? IDLE : WAIT_HI;
    end else if (in_is_load && in_split) begin
      state_n = accept ? WAIT_HI : IDLE;
    end else begin
      res = in_is_load ? extend(in_rdata >> {in_alu_result[1:0], 3'b000}, in_load_op) : in_alu_result;
      enq = accept;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) err_split <= 1'b0;
    else if (accept && in_is_load && in_split) err_split <= 1'b1;
  end

  // Without merge support a crossing load just sees zeros shifted in above bit 31.
  always_comb begin
    enq    = accept;
    res_rd = in_rd;
    res    = in_is_load ? extend(in_rdata >> {in_alu_result[1:0], 3'b000}, in_load_op) : in_alu_result;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        rd_q[wr_ptr]   <= res_rd;
        data_q[wr_ptr] <= res;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule
